// File: rtl/obstacle_stream_generator.sv
// obstacle_stream_generator
//   Scrolling NUM_ROWS x NUM_LANES grid of half-block obstacle cells. Each
//   frame (started by `activate`) scrolls the grid by `speed` depth units.
//   When a whole row has scrolled past, new obstacles may spawn at the far
//   rows. Spawning is driven by a 32-bit Galois LFSR and `cfg_density`.
//   The visible obstacles are then streamed out over a valid/ready handshake.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   activate       pulse: start one frame (ignored while busy, except in the done cycle)
//   speed          depth units scrolled per frame
//   cfg_density    spawn probability per lane in eighths (0 = never)
//   out_valid      out_obstacle / out_first_row hold a valid obstacle
//   out_ready      consumer accepts the current obstacle
//   out_obstacle   {type[2:0], lane[LW-1:0], depth[DEPTH_W-1:0]}
//   out_first_row  obstacle lies in the player row
//   busy           frame in progress
//   done           one-cycle pulse, frame complete
//
// Cell encoding: {front, type[2:0]}. Cars (100) and ramps (101) span two rows:
// front half at row r, rear half at row r+1. Only rear halves and barriers
// are streamed.

// Per-lane spawn decision for the cycle after a scroll.
// U is the second-to-last row; T is the top row, which was just cleared.
module obstacle_lane_spawn #(
    parameter int RAMP_CARS = 3,
    parameter int FW        = 2
) (
    input  logic [5:0]    i_rand,     // this lane's LFSR bits
    input  logic [2:0]    i_density,
    input  logic [FW-1:0] i_follow,   // cars still owed behind a ramp
    input  logic [2:0]    i_type_u,   // type of cell at row U
    input  logic          i_t2_car,   // type[2] of cell at row T-2
    output logic          o_wr_u,
    output logic          o_wr_t,
    output logic [3:0]    o_cell_u,
    output logic [3:0]    o_cell_t,
    output logic [FW-1:0] o_follow
);
    logic       w_u_empty;
    logic [2:0] w_type;

    assign w_u_empty = (i_type_u == 3'b000);

    always_comb begin
        o_wr_u   = 1'b0;
        o_wr_t   = 1'b0;
        o_cell_u = '0;
        o_cell_t = '0;
        o_follow = i_follow;
        w_type   = 3'b000;
        if (i_follow != '0) begin
            // A pending train car waits until row U is free. This keeps the train contiguous.
            if (w_u_empty) begin
                o_wr_u   = 1'b1;
                o_wr_t   = 1'b1;
                o_cell_u = {1'b1, 3'b100};
                o_cell_t = {1'b0, 3'b100};
                o_follow = i_follow - FW'(1);
            end
        end else if ((i_rand[2:0] < i_density) && w_u_empty) begin
            if (!i_rand[3] && !i_t2_car) begin
                case (i_rand[5:4])
                    2'b00:   w_type = 3'b001;
                    2'b01:   w_type = 3'b010;
                    default: w_type = 3'b011;
                endcase
                o_wr_t   = 1'b1;
                o_cell_t = {1'b0, w_type};
            end else begin
                w_type   = (i_rand[5:4] == 2'b00) ? 3'b101 : 3'b100;
                o_wr_u   = 1'b1;
                o_wr_t   = 1'b1;
                o_cell_u = {1'b1, w_type};
                o_cell_t = {1'b0, w_type};
                if (i_rand[5:4] == 2'b00) o_follow = FW'(RAMP_CARS);
            end
        end
    end
endmodule

module obstacle_stream_generator #(
    parameter int          NUM_LANES = 3,
    parameter int          NUM_ROWS  = 16,
    parameter int          ROW_DEPTH = 64,
    parameter int          DEPTH_W   = 11,
    parameter int          NEAR_ROW  = 3,
    parameter int          RAMP_CARS = 3,
    parameter logic [31:0] SEED      = 32'h1,
    localparam int         LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      activate,
    input  logic [3:0]                speed,
    input  logic [2:0]                cfg_density,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3+LW+DEPTH_W-1:0]   out_obstacle,
    output logic                      out_first_row,
    output logic                      busy,
    output logic                      done
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int OW = $clog2(ROW_DEPTH);
    localparam int FW = (RAMP_CARS < 1) ? 1 : $clog2(RAMP_CARS + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADVANCE, S_GENERATE, S_EMIT, S_FINISH} state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]                               r_lfsr;
    logic [NUM_ROWS-1:0][NUM_LANES-1:0][3:0]   r_cells;
    logic [NUM_LANES-1:0][FW-1:0]              r_follow;
    logic [OW-1:0]                             r_offset;
    logic [RW-1:0]                             r_row;
    logic [LW-1:0]                             r_lane;
    logic                                      r_out_valid;
    logic [3+LW+DEPTH_W-1:0]                   r_out_obstacle;
    logic                                      r_out_first;

    logic [31:0]                  w_lfsr_nxt;
    logic [OW:0]                  w_sum;
    logic [NUM_LANES-1:0]         w_wr_u, w_wr_t;
    logic [NUM_LANES-1:0][3:0]    w_cell_u, w_cell_t;
    logic [NUM_LANES-1:0][FW-1:0] w_follow_nxt;
    logic [3:0]                   w_cell;
    logic                         w_scan, w_emit, w_last, w_first;
    logic [DEPTH_W-1:0]           w_depth;

    assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);

    // speed < 16 <= ROW_DEPTH, so the sum is always below 2*ROW_DEPTH.
    // The MSB is the scroll flag, and the low bits are the new offset in both cases.
    assign w_sum = {1'b0, r_offset} + (OW+1)'(speed);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        obstacle_lane_spawn #(.RAMP_CARS(RAMP_CARS), .FW(FW)) u_spawn (
            .i_rand    (r_lfsr[6*l +: 6]),
            .i_density (cfg_density),
            .i_follow  (r_follow[l]),
            .i_type_u  (r_cells[NUM_ROWS-2][l][2:0]),
            .i_t2_car  (r_cells[NUM_ROWS-3][l][2]),
            .o_wr_u    (w_wr_u[l]),
            .o_wr_t    (w_wr_t[l]),
            .o_cell_u  (w_cell_u[l]),
            .o_cell_t  (w_cell_t[l]),
            .o_follow  (w_follow_nxt[l])
        );
    end

    // Emission scan: one cell per cycle. The scan stalls while the output register holds an untaken obstacle.
    assign w_cell  = r_cells[r_row][r_lane];
    assign w_scan  = (r_state == S_EMIT) && (!r_out_valid || out_ready);
    assign w_emit  = (w_cell[2:0] != 3'b000) && !w_cell[3];
    assign w_last  = (r_row == RW'(NUM_ROWS-1)) && (r_lane == LW'(NUM_LANES-1));
    assign w_depth = ((DEPTH_W'(r_row) + DEPTH_W'(1)) << OW) - DEPTH_W'(r_offset);
    assign w_first = (r_row == RW'(NEAR_ROW)) || ((r_row == RW'(NEAR_ROW+1)) && w_cell[2]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            S_IDLE:     if (activate) w_state_nxt = S_ADVANCE;
            S_ADVANCE:  w_state_nxt = w_sum[OW] ? S_GENERATE : S_EMIT;
            S_GENERATE: w_state_nxt = S_EMIT;
            S_EMIT:     if (w_scan && w_last) w_state_nxt = S_FINISH;
            S_FINISH: begin
                // Wait for the final obstacle, if any, to be taken.
                if (!r_out_valid || out_ready) begin
                    done        = 1'b1;
                    w_state_nxt = activate ? S_ADVANCE : S_IDLE;
                end
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr         <= SEED;
            r_cells        <= '0;
            r_follow       <= '0;
            r_offset       <= '0;
            r_row          <= '0;
            r_lane         <= '0;
            r_out_valid    <= 1'b0;
            r_out_obstacle <= '0;
            r_out_first    <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (r_state == S_ADVANCE) begin
                r_offset <= w_sum[OW-1:0];
                r_row    <= '0;
                r_lane   <= '0;
                if (w_sum[OW]) begin
                    for (int i = 0; i < NUM_ROWS-1; i++) r_cells[i] <= r_cells[i+1];
                    r_cells[NUM_ROWS-1] <= '0;
                end
            end
            if (r_state == S_GENERATE) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (w_wr_u[l]) r_cells[NUM_ROWS-2][l] <= w_cell_u[l];
                    if (w_wr_t[l]) r_cells[NUM_ROWS-1][l] <= w_cell_t[l];
                end
                r_follow <= w_follow_nxt;
            end
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_scan) begin
                if (w_emit) begin
                    r_out_valid    <= 1'b1;
                    r_out_obstacle <= {w_cell[2:0], r_lane, w_depth};
                    r_out_first    <= w_first;
                end
                if (r_lane == LW'(NUM_LANES-1)) begin
                    r_lane <= '0;
                    r_row  <= r_row + RW'(1);
                end else begin
                    r_lane <= r_lane + LW'(1);
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_obstacle  = r_out_obstacle;
    assign out_first_row = r_out_first;
    assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_obstacle_stream_generator.sv
// tb_obstacle_stream_generator
//   Drives randomized frames into obstacle_stream_generator with the default
//   parameters: 3 lanes, 16 rows, 64 depth units per row.
//   Each transferred obstacle is compared against a grid-level reference model.
//   The model tracks lane/row occupancy, scroll offset, ramp follow counts and the LFSR.
module tb_obstacle_stream_generator;
    localparam int NL = 3;
    localparam int NR = 16;
    localparam int RD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        activate = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [2:0]  cfg_density = 3'd0;
    logic        out_ready = 1'b1;
    logic        out_valid, out_first_row, busy, done;
    logic [15:0] out_obstacle;

    obstacle_stream_generator dut (
        .clk           (clk),
        .rst           (rst),
        .activate      (activate),
        .speed         (speed),
        .cfg_density   (cfg_density),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_obstacle  (out_obstacle),
        .out_first_row (out_first_row),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference LFSR: reloads in reset, otherwise steps on every clock.
    logic [31:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 32'h1;
        else     m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
    end

    int          m_typ   [NR][NL];
    bit          m_front [NR][NL];
    int          m_follow[NL];
    int          m_off;
    bit          m_scroll;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int l = 0; l < NL; l++) begin
                m_typ[r][l]   = 0;
                m_front[r][l] = 1'b0;
            end
        for (int l = 0; l < NL; l++) m_follow[l] = 0;
        m_off = 0;
    endtask

    task automatic model_advance(input int spd);
        m_scroll = (m_off + spd >= RD);
        if (m_scroll) begin
            for (int r = 0; r < NR-1; r++)
                for (int l = 0; l < NL; l++) begin
                    m_typ[r][l]   = m_typ[r+1][l];
                    m_front[r][l] = m_front[r+1][l];
                end
            for (int l = 0; l < NL; l++) begin
                m_typ[NR-1][l]   = 0;
                m_front[NR-1][l] = 1'b0;
            end
            m_off = m_off + spd - RD;
        end else begin
            m_off = m_off + spd;
        end
    endtask

    task automatic place_car(input int l, input int ty);
        m_typ[NR-2][l] = ty; m_front[NR-2][l] = 1'b1;
        m_typ[NR-1][l] = ty; m_front[NR-1][l] = 1'b0;
    endtask

    task automatic model_generate(input logic [31:0] s, input int dens);
        for (int l = 0; l < NL; l++) begin
            int  b, hi;
            bit  u_empty;
            b       = int'((s >> (6*l)) & 32'h3f);
            hi      = (b >> 4) & 3;
            u_empty = (m_typ[NR-2][l] == 0);
            if (m_follow[l] != 0) begin
                if (u_empty) begin
                    place_car(l, 4);
                    m_follow[l]--;
                end
            end else if ((b & 7) < dens && u_empty) begin
                if (((b >> 3) & 1) == 0 && m_typ[NR-3][l] < 4) begin
                    m_typ[NR-1][l]   = (hi == 0) ? 1 : (hi == 1) ? 2 : 3;
                    m_front[NR-1][l] = 1'b0;
                end else if (hi == 0) begin
                    place_car(l, 5);
                    m_follow[l] = 3;
                end else begin
                    place_car(l, 4);
                end
            end
        end
    endtask

    task automatic model_build();
        exp_q.delete();
        for (int r = 0; r < NR; r++)
            for (int l = 0; l < NL; l++)
                if (m_typ[r][l] != 0 && !m_front[r][l]) begin
                    logic [2:0]  ty;
                    logic [1:0]  ln;
                    logic [10:0] dp;
                    logic        fr;
                    ty = 3'(m_typ[r][l]);
                    ln = 2'(l);
                    dp = 11'((r+1)*RD - m_off);
                    fr = (r == 3) || (r == 4 && m_typ[r][l] >= 4);
                    exp_q.push_back({ty, ln, dp, fr});
                end
    endtask

    // One frame. Entered and left just after a falling edge.
    // rmode 0: ready tied high. rmode 1: random backpressure.
    // inject: pulse activate mid-frame. The DUT must ignore these pulses.
    task automatic run_frame(input int spd, input int dens, input int rmode, input bit inject);
        int cnt, lat, ntx, nexp;
        lat  = -1;
        ntx  = 0;
        nexp = 0;
        speed       = 4'(spd);
        cfg_density = 3'(dens);
        out_ready   = 1'b1;
        activate    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt = 1;
        while (cnt <= 600) begin
            out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            activate  = inject && (cnt == 10 || cnt == 25);
            #1;
            if (cnt == 1) model_advance(spd);
            if (cnt == 2) begin
                if (m_scroll) model_generate(m_lfsr, dens);
                model_build();
                nexp = exp_q.size();
            end
            if (out_valid) begin
                check("payload", {15'd0, out_obstacle, out_first_row},
                      {15'd0, (exp_q.size() > 0) ? exp_q[0] : 17'h1ffff});
                if (out_ready) begin
                    ntx++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                lat = cnt;
                break;
            end
            @(negedge clk);
            cnt++;
        end
        activate = 1'b0;
        if (rmode == 0) check("done_latency", lat, 50 + int'(m_scroll));
        else            check("done_seen", 32'(lat > 0), 32'd1);
        check("obstacle_count", ntx, nexp);
        @(negedge clk);
        #1;
        check("after_done", {29'd0, out_valid, busy, done}, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {29'd0, out_valid, busy, done}, 32'd0);
        check("reset_payload", {16'd0, out_obstacle}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty grid, speed 5: frames 1..12 only move the offset; frame 13 scrolls.
        for (int f = 0; f < 13; f++) run_frame(5, 0, 0, 1'b0);
        check("offset_after_13", m_off, 1);

        // Dense random traffic, ready tied high
        for (int f = 0; f < 200; f++) run_frame(int'($urandom_range(0, 15)), 7, 0, 1'b0);

        // Backpressure
        for (int f = 0; f < 60; f++) run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1, 1'b0);

        // Long dense run: exercises the ramp/train and barrier-placement rules
        for (int f = 0; f < 300; f++) run_frame(int'($urandom_range(8, 15)), 7, 0, 1'b0);

        // Ignored activate while busy. Speed 0 gives repeated identical streams.
        run_frame(9, 5, 0, 1'b1);
        run_frame(0, 7, 0, 1'b1);
        run_frame(0, 7, 1, 1'b1);

        // Reset asserted mid-emission
        speed       = 4'd3;
        cfg_density = 3'd7;
        activate    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        activate = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midreset_ctrl", {29'd0, out_valid, busy, done}, 32'd0);
        check("midreset_payload", {16'd0, out_obstacle}, 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_frame(5, 0, 0, 1'b0);
        run_frame(15, 0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
